// File: rtl/data_sramlike_bridge.sv
// data_sramlike_bridge: turns the core's single-cycle data strobe into a two-phase sram-like
// transaction, stalling the core until the response arrives and holding read data for it.
module data_sramlike_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        d_stall,
    input  logic        longest_stall,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
    state_t state, nextState;
    logic        wrQ, wrC, reqC, latch, capture, idle;
    logic [1:0]  sizeQ, sizeC, loC;
    logic [31:0] addrQ, wdataQ, rdataQ, addrC;
    always_comb begin
        wrC = |data_sram_wen;
        sizeC = 2'd2;
        loC = 2'd0;
        case (data_sram_wen)
            4'b0011: sizeC = 2'd1;
            4'b1100: begin sizeC = 2'd1; loC = 2'd2; end
            4'b0001: sizeC = 2'd0;
            4'b0010: begin sizeC = 2'd0; loC = 2'd1; end
            4'b0100: begin sizeC = 2'd0; loC = 2'd2; end
            4'b1000: begin sizeC = 2'd0; loC = 2'd3; end
            default: ;
        endcase
        addrC = (data_sram_addr & 32'hFFFF_FFFC) | {30'd0, loC};
    end
    always_comb begin
        nextState = state;
        reqC = 1'b0;
        latch = 1'b0;
        capture = 1'b0;
        case (state)
            IDLE: begin
                reqC = data_sram_en;
                latch = data_sram_en;
                if (data_sram_en) nextState = data_addr_ok ? DATA : ADDR;
            end
            ADDR: begin
                reqC = 1'b1;
                if (data_addr_ok) nextState = DATA;
            end
            DATA: if (data_data_ok) begin
                // a flushed access still completes on the bus but its data is dropped
                capture = data_sram_en & ~wrQ;
                nextState = data_sram_en ? DONE : IDLE;
            end
            DONE: if (!longest_stall || !data_sram_en) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end
    assign idle = state == IDLE;
    assign data_req = rst & reqC;
    assign d_stall = rst & data_sram_en & (state != DONE);
    assign data_wr = idle ? wrC : wrQ;
    assign data_size = idle ? sizeC : sizeQ;
    assign data_addr = idle ? addrC : addrQ;
    assign data_wdata = idle ? data_sram_wdata : wdataQ;
    assign data_sram_rdata = rdataQ;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            wrQ <= 1'b0;
            sizeQ <= 2'd0;
            addrQ <= 32'd0;
            wdataQ <= 32'd0;
            rdataQ <= 32'd0;
        end else begin
            state <= nextState;
            if (latch) begin
                wrQ <= wrC;
                sizeQ <= sizeC;
                addrQ <= addrC;
                wdataQ <= data_sram_wdata;
            end
            if (capture) rdataQ <= data_rdata;
        end
    end
endmodule
